// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - signed radix-2 restoring divider, fixed 33-cycle latency
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   input1,
    input  logic [WIDTH-1:0]   input2,
    output logic [2*WIDTH-1:0] output1,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam int CW = $clog2(WIDTH) + 1;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   orig_q, orig_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic               zero_q, zero_d;
    logic [2*WIDTH-1:0] out_q, out_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]     rem_sh, rem_sub;
    logic [WIDTH-1:0]   q_fix, r_fix;

    // quo_q starts as the dividend magnitude; its bits shift out into rem while quotient bits shift in.
    always_comb begin
        rem_sh  = {rem_q, quo_q[WIDTH-1]};
        rem_sub = rem_sh - {1'b0, dvs_q};
        q_fix   = negq_q ? (~quo_q + 1'b1) : quo_q;
        r_fix   = negr_q ? (~rem_q + 1'b1) : rem_q;

        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        orig_d  = orig_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        zero_d  = zero_q;
        out_d   = out_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    negr_d  = input1[WIDTH-1];
                    negq_d  = input1[WIDTH-1] ^ input2[WIDTH-1];
                    quo_d   = input1[WIDTH-1] ? (~input1 + 1'b1) : input1;
                    dvs_d   = input2[WIDTH-1] ? (~input2 + 1'b1) : input2;
                    orig_d  = input1;
                    zero_d  = (input2 == '0);
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (!rem_sub[WIDTH]) begin
                    rem_d = rem_sub[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                out_d   = zero_q ? {orig_q, {WIDTH{1'b1}}} : {r_fix, q_fix};
                dbz_d   = zero_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            orig_q  <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            zero_q  <= 1'b0;
            out_q   <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            orig_q  <= orig_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            zero_q  <= zero_d;
            out_q   <= out_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign output1     = out_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule
